// File: rtl/l1_mshr_entry_release_if.sv
// rtl/l1_mshr_entry_release_if.sv - alloc/memrsp/response bundle for the MSHR entry release block
interface l1_mshr_entry_release_if #(
    parameter int NUM_ENTRY = 4,
    parameter int NUM_SUB   = 4
);
    localparam int EW = $clog2(NUM_ENTRY);
    localparam int SW = $clog2(NUM_SUB);

    logic                 alloc_valid_i;
    logic [EW-1:0]        alloc_entry_i;
    logic                 alloc_secondary_i;
    logic                 memrsp_valid_i;
    logic [EW-1:0]        memrsp_entry_i;
    logic                 out_valid_o;
    logic [EW-1:0]        out_entry_o;
    logic [SW-1:0]        out_sub_o;
    logic                 out_last_o;
    logic                 out_ready_i;
    logic [NUM_ENTRY-1:0] valid_list_o;
    logic [NUM_ENTRY-1:0] sub_full_o;

    modport master (
        output alloc_valid_i, alloc_entry_i, alloc_secondary_i,
        output memrsp_valid_i, memrsp_entry_i, out_ready_i,
        input  out_valid_o, out_entry_o, out_sub_o, out_last_o,
        input  valid_list_o, sub_full_o
    );

    modport slave (
        input  alloc_valid_i, alloc_entry_i, alloc_secondary_i,
        input  memrsp_valid_i, memrsp_entry_i, out_ready_i,
        output out_valid_o, out_entry_o, out_sub_o, out_last_o,
        output valid_list_o, sub_full_o
    );
endinterface

// File: rtl/l1_mshr_entry_release.sv
// rtl/l1_mshr_entry_release.sv - per-entry MSHR state and sub-entry drain toward the core response path
module l1_mshr_entry_release #(
    parameter int NUM_ENTRY = 4,
    parameter int NUM_SUB   = 4
) (
    input  logic clk,
    input  logic rst_n,
    l1_mshr_entry_release_if.slave bus
);
    localparam int EW = $clog2(NUM_ENTRY);
    localparam int SW = $clog2(NUM_SUB);
    localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);
    localparam logic [SW:0] CNT_FULL = (SW+1)'(NUM_SUB);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} ent_t;
    typedef enum logic {S_SEL, S_DRAIN} fsm_t;

    ent_t          st_q  [NUM_ENTRY];
    ent_t          st_d  [NUM_ENTRY];
    logic [SW:0]   cnt_q [NUM_ENTRY];
    logic [SW:0]   cnt_d [NUM_ENTRY];
    fsm_t          fsm_q, fsm_d;
    logic [EW-1:0] cur_q, cur_d;
    logic [SW-1:0] sub_q, sub_d;

    logic          any_ready;
    logic [EW-1:0] sel_idx;
    logic          hs;
    logic          last;

    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        // descending scan so the lowest READY index wins
        for (int e = NUM_ENTRY - 1; e >= 0; e--) begin
            if (st_q[e] == ST_READY) begin
                any_ready = 1'b1;
                sel_idx   = EW'(e);
            end
        end
    end

    assign last = ({1'b0, sub_q} == (cnt_q[cur_q] - CNT_ONE));
    assign hs   = (fsm_q == S_DRAIN) && bus.out_ready_i;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        fsm_d = fsm_q;
        cur_d = cur_q;
        sub_d = sub_q;
        for (int e = 0; e < NUM_ENTRY; e++) begin
            if (bus.alloc_valid_i && bus.alloc_entry_i == EW'(e)) begin
                if (!bus.alloc_secondary_i) begin
                    if (st_q[e] == ST_IDLE) begin
                        st_d[e]  = ST_WAIT;
                        cnt_d[e] = CNT_ONE;
                    end
                end else if (st_q[e] == ST_WAIT && cnt_q[e] != CNT_FULL) begin
                    cnt_d[e] = cnt_q[e] + CNT_ONE;
                end
            end
            if (bus.memrsp_valid_i && bus.memrsp_entry_i == EW'(e) && st_q[e] == ST_WAIT) begin
                st_d[e] = ST_READY;
            end
        end
        case (fsm_q)
            S_SEL: begin
                if (any_ready) begin
                    cur_d = sel_idx;
                    sub_d = '0;
                    fsm_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hs) begin
                    if (last) begin
                        st_d[cur_q]  = ST_IDLE;
                        cnt_d[cur_q] = '0;
                        fsm_d        = S_SEL;
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                end
            end
            default: fsm_d = S_SEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_ENTRY; e++) begin
                st_q[e]  <= ST_IDLE;
                cnt_q[e] <= '0;
            end
            fsm_q <= S_SEL;
            cur_q <= '0;
            sub_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            fsm_q <= fsm_d;
            cur_q <= cur_d;
            sub_q <= sub_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && bus.alloc_valid_i && !bus.alloc_secondary_i) begin
            assert (st_q[bus.alloc_entry_i] == ST_IDLE)
                else $warning("primary alloc to busy entry %0d ignored", bus.alloc_entry_i);
        end
    end

    assign bus.out_valid_o = (fsm_q == S_DRAIN);
    assign bus.out_entry_o = cur_q;
    assign bus.out_sub_o   = sub_q;
    assign bus.out_last_o  = (fsm_q == S_DRAIN) && last;

    always_comb begin
        for (int e = 0; e < NUM_ENTRY; e++) begin
            bus.valid_list_o[e] = (st_q[e] != ST_IDLE);
            bus.sub_full_o[e]   = (cnt_q[e] == CNT_FULL);
        end
    end
endmodule
